byte_packer: RTL and testbench

- Reverse of the word splitter: collects a stream of 8-bit bytes and packs them into 32-bit words.
- Sits between byte-wide sources (UART RX, byte-addressed loaders) and 32-bit consumers (instruction/data memory fill, register write).
- Valid/ready handshake on both sides; a single output word register.
- Partial words can be flushed with a last-byte marker.

---
 rtl/byte_packer.sv | 86 ++++++++
 tb/tb_byte_packer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/byte_packer.sv
// Packs a stream of bytes into 32-bit words with valid/ready on both sides.
// A word is emitted after four bytes, or earlier when the producer marks the last byte.
module byte_packer #(
   parameter int BIG_ENDIAN = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [7:0]  in_byte,
   input  logic        in_last,
   output logic        in_ready,
   output logic        out_valid,
   output logic [31:0] out_word,
   output logic [2:0]  out_bytes,
   input  logic        out_ready
);

   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] acc_q, acc_d;
   logic        vld_q, vld_d;
   logic [31:0] word_q, word_d;
   logic [2:0]  bytes_q, bytes_d;

   logic        accept;
   logic        complete;
   logic [4:0]  shamt;
   logic [31:0] placed;
   logic [31:0] merged;

   // A held word may still be taken this cycle, which frees the register for a new one.
   assign in_ready  = !vld_q || out_ready;
   assign out_valid = vld_q;
   assign out_word  = word_q;
   assign out_bytes = bytes_q;

   always_comb begin
      accept   = in_valid && in_ready;
      complete = accept && (in_last || (cnt_q == 2'd3));
      shamt    = {cnt_q, 3'b000};
      if (BIG_ENDIAN != 0) begin
         placed = {in_byte, 24'h000000} >> shamt;
      end else begin
         placed = {24'h000000, in_byte} << shamt;
      end
      // Unfilled slots of the accumulator are always zero, so OR-merge is exact.
      merged = acc_q | placed;

      cnt_d   = cnt_q;
      acc_d   = acc_q;
      vld_d   = vld_q;
      word_d  = word_q;
      bytes_d = bytes_q;

      if (vld_q && out_ready) begin
         vld_d = 1'b0;
      end

      if (complete) begin
         word_d  = merged;
         bytes_d = {1'b0, cnt_q} + 3'd1;
         vld_d   = 1'b1;
         cnt_d   = 2'd0;
         acc_d   = 32'h0;
      end else if (accept) begin
         acc_d = merged;
         cnt_d = cnt_q + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q   <= 2'd0;
         acc_q   <= 32'h0;
         vld_q   <= 1'b0;
         word_q  <= 32'h0;
         bytes_q <= 3'd0;
      end else begin
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         vld_q   <= vld_d;
         word_q  <= word_d;
         bytes_q <= bytes_d;
      end
   end

endmodule

// File: tb/tb_byte_packer.sv
// Directed bench for byte_packer: big-endian and little-endian instances share one input stream.
module tb_byte_packer;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [7:0]  in_byte;
   logic        in_last;
   logic        out_ready;

   logic        be_in_ready, le_in_ready;
   logic        be_out_valid, le_out_valid;
   logic [31:0] be_out_word, le_out_word;
   logic [2:0]  be_out_bytes, le_out_bytes;

   int n_chk;
   int n_pass;

   byte_packer #(.BIG_ENDIAN(1)) dut_be (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_byte(in_byte),
      .in_last(in_last), .in_ready(be_in_ready), .out_valid(be_out_valid),
      .out_word(be_out_word), .out_bytes(be_out_bytes), .out_ready(out_ready)
   );

   byte_packer #(.BIG_ENDIAN(0)) dut_le (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_byte(in_byte),
      .in_last(in_last), .in_ready(le_in_ready), .out_valid(le_out_valid),
      .out_word(le_out_word), .out_bytes(le_out_bytes), .out_ready(out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input logic last);
      in_valid = 1'b1;
      in_byte  = b;
      in_last  = last;
      tick();
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_last  = 1'b0;
      tick();
   endtask

   initial begin
      n_chk     = 0;
      n_pass    = 0;
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_byte   = 8'h00;
      in_last   = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      chk("rst_vld",   {31'b0, be_out_valid}, 32'h0);
      chk("rst_word",  be_out_word, 32'h0);
      chk("rst_bytes", {29'b0, be_out_bytes}, 32'h0);
      chk("rst_rdy",   {31'b0, be_in_ready}, 32'h1);
      reset = 1'b1;
      tick();

      // Full big-endian word
      send(8'h12, 1'b0);
      send(8'h34, 1'b0);
      send(8'h56, 1'b0);
      chk("w1_early_vld", {31'b0, be_out_valid}, 32'h0);
      send(8'h78, 1'b0);
      chk("w1_vld",   {31'b0, be_out_valid}, 32'h1);
      chk("w1_word",  be_out_word, 32'h12345678);
      chk("w1_bytes", {29'b0, be_out_bytes}, 32'h4);
      idle();
      chk("w1_fall",  {31'b0, be_out_valid}, 32'h0);
      chk("w1_hold",  be_out_word, 32'h12345678);

      // Partial word flushed by in_last, then a fresh full word
      send(8'hAA, 1'b0);
      send(8'hBB, 1'b1);
      chk("p2_vld",   {31'b0, be_out_valid}, 32'h1);
      chk("p2_word",  be_out_word, 32'hAABB0000);
      chk("p2_bytes", {29'b0, be_out_bytes}, 32'h2);
      send(8'h01, 1'b0);
      chk("p2_taken", {31'b0, be_out_valid}, 32'h0);
      send(8'h02, 1'b0);
      send(8'h03, 1'b0);
      send(8'h04, 1'b0);
      chk("w3_word",  be_out_word, 32'h01020304);
      chk("w3_bytes", {29'b0, be_out_bytes}, 32'h4);
      idle();

      // Stall: word held, no bytes accepted until taken
      out_ready = 1'b0;
      send(8'hDE, 1'b0);
      send(8'hAD, 1'b0);
      send(8'hBE, 1'b0);
      send(8'hEF, 1'b0);
      chk("st_vld",  {31'b0, be_out_valid}, 32'h1);
      for (int i = 0; i < 5; i++) begin
         send(8'h11, 1'b0);
         chk("st_rdy",  {31'b0, be_in_ready}, 32'h0);
         chk("st_word", be_out_word, 32'hDEADBEEF);
      end
      chk("st_vld_hold", {31'b0, be_out_valid}, 32'h1);
      out_ready = 1'b1;
      #1;
      chk("st_rdy_up", {31'b0, be_in_ready}, 32'h1);
      tick();
      chk("st_taken", {31'b0, be_out_valid}, 32'h0);
      send(8'h22, 1'b0);
      send(8'h33, 1'b0);
      send(8'h44, 1'b0);
      chk("st_next_vld",  {31'b0, be_out_valid}, 32'h1);
      chk("st_next_word", be_out_word, 32'h11223344);
      idle();

      // Streaming eight bytes with out_ready held high
      for (int i = 0; i < 8; i++) begin
         send(i[7:0], 1'b0);
         if (i == 3) begin
            chk("sm_w0_vld",  {31'b0, be_out_valid}, 32'h1);
            chk("sm_w0_word", be_out_word, 32'h00010203);
         end
         if (i == 4) chk("sm_gap_vld", {31'b0, be_out_valid}, 32'h0);
      end
      chk("sm_w1_vld",  {31'b0, be_out_valid}, 32'h1);
      chk("sm_w1_word", be_out_word, 32'h04050607);

      // Take and completing accept in the same cycle: no bubble
      send(8'hA1, 1'b1);
      chk("bb_a1_vld",   {31'b0, be_out_valid}, 32'h1);
      chk("bb_a1_word",  be_out_word, 32'hA1000000);
      chk("bb_a1_bytes", {29'b0, be_out_bytes}, 32'h1);
      send(8'hA2, 1'b1);
      chk("bb_a2_vld",   {31'b0, be_out_valid}, 32'h1);
      chk("bb_a2_word",  be_out_word, 32'hA2000000);
      idle();

      // Asynchronous reset discards a partial word
      send(8'h55, 1'b0);
      send(8'h66, 1'b0);
      in_valid = 1'b0;
      #3;
      reset = 1'b0;
      #1;
      chk("ar_vld",  {31'b0, be_out_valid}, 32'h0);
      chk("ar_word", be_out_word, 32'h0);
      chk("ar_bytes", {29'b0, be_out_bytes}, 32'h0);
      tick();
      #2;
      reset = 1'b1;
      tick();
      send(8'h9A, 1'b0);
      send(8'hBC, 1'b0);
      chk("ar_bc_vld", {31'b0, be_out_valid}, 32'h0);
      send(8'hDE, 1'b0);
      chk("ar_de_vld", {31'b0, be_out_valid}, 32'h0);
      send(8'hF0, 1'b0);
      chk("ar_w_vld",  {31'b0, be_out_valid}, 32'h1);
      chk("ar_w_word", be_out_word, 32'h9ABCDEF0);
      idle();

      // Little-endian placement
      send(8'h12, 1'b0);
      send(8'h34, 1'b0);
      send(8'h56, 1'b0);
      send(8'h78, 1'b0);
      chk("le_vld",   {31'b0, le_out_valid}, 32'h1);
      chk("le_word",  le_out_word, 32'h78563412);
      chk("le_bytes", {29'b0, le_out_bytes}, 32'h4);
      send(8'hAB, 1'b1);
      chk("le_p_word",  le_out_word, 32'h000000AB);
      chk("le_p_bytes", {29'b0, le_out_bytes}, 32'h1);
      chk("be_p_word",  be_out_word, 32'hAB000000);
      idle();
      chk("le_fall", {31'b0, le_out_valid}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
